// File: rtl/mips_defines.sv
// mips_defines: shared definitions for the execute-stage divider.
//   div_state_t : divider FSM state encoding (2 bits)
//   DIV_CYCLES  : restoring-division iteration count (one per operand bit)
package mips_defines;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

  localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for MIPS DIV/DIVU in the E stage.
//   clk, rst    : pipeline clock, asynchronous active-high reset
//   startE      : DIV/DIVU occupies E this cycle
//   signedE     : 1 = DIV (two's complement), 0 = DIVU
//   annulE      : cancel the division (exception / flush)
//   aE, bE      : dividend, divisor (sampled only when the division starts)
//   stall_divE  : freeze F/D/E while the division is in flight
//   div_validE  : HI/LO write enable, high exactly in the DONE cycle
//   hiE, loE    : remainder, quotient; hold until the next DONE
module div_unit
  import mips_defines::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic             annulE,
  input  logic [WIDTH-1:0] aE,
  input  logic [WIDTH-1:0] bE,
  output logic             stall_divE,
  output logic             div_validE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       r_state;
  div_state_t       w_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_qneg;
  logic             r_rneg;

  // Two's-complement negation when neg is set (magnitude and sign fixup).
  function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  logic             w_start;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH:0]   w_shrem;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic             w_last;
  logic             w_done;
  logic [WIDTH-1:0] w_hi_fix;
  logic [WIDTH-1:0] w_lo_fix;

  assign w_start  = startE & ~annulE;
  assign w_a_neg  = signedE & aE[WIDTH-1];
  assign w_b_neg  = signedE & bE[WIDTH-1];
  // Shifted partial remainder: old remainder with the next dividend bit appended.
  // Kept WIDTH+1 wide so the trial difference's top bit is the borrow.
  assign w_shrem  = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = w_shrem - {1'b0, r_div};
  assign w_ge     = ~w_trial[WIDTH];
  assign w_last   = (r_count == CW'(WIDTH - 1));
  assign w_done   = (r_state == DIV_DONE) & ~annulE;
  assign w_hi_fix = f_cond_neg(r_rem, r_rneg);
  assign w_lo_fix = f_cond_neg(r_quo, r_qneg);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; annul always returns to IDLE.
  always_comb begin
    w_next = DIV_IDLE;
    case (r_state)
      DIV_IDLE: w_next = w_start ? DIV_BUSY : DIV_IDLE;
      DIV_BUSY: begin
        if (annulE) begin
          w_next = DIV_IDLE;
        end else if (w_last) begin
          w_next = DIV_DONE;
        end else begin
          w_next = DIV_BUSY;
        end
      end
      DIV_DONE: w_next = DIV_IDLE;
      default:  w_next = DIV_IDLE;
    endcase
  end

  // Outputs: stall rises combinationally with startE; results are shown
  // sign-fixed during DONE and held from the HI/LO registers otherwise.
  always_comb begin
    stall_divE = ~annulE & (((r_state == DIV_IDLE) & startE) | (r_state == DIV_BUSY));
    div_validE = w_done;
    if (w_done) begin
      hiE = w_hi_fix;
      loE = w_lo_fix;
    end else begin
      hiE = r_hi;
      loE = r_lo;
    end
  end

  // Datapath: operand capture, one restoring step per BUSY cycle, result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_start) begin
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= f_cond_neg(aE, w_a_neg);
            r_div   <= f_cond_neg(bE, w_b_neg);
            r_qneg  <= w_a_neg ^ w_b_neg;
            r_rneg  <= w_a_neg;
          end
        end
        DIV_BUSY: begin
          if (!annulE) begin
            r_rem   <= w_ge ? w_trial[WIDTH-1:0] : w_shrem[WIDTH-1:0];
            r_quo   <= {r_quo[WIDTH-2:0], w_ge};
            r_count <= r_count + CW'(1);
          end
        end
        DIV_DONE: begin
          if (!annulE) begin
            r_hi <= w_hi_fix;
            r_lo <= w_lo_fix;
          end
        end
        default: begin
          r_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized self-checking bench for div_unit against an
// arithmetic reference model (SV integer divide with MIPS zero-divisor rules).
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic        signedE;
  logic        annulE;
  logic [31:0] aE;
  logic [31:0] bE;
  logic        stall_divE;
  logic        div_validE;
  logic [31:0] hiE;
  logic [31:0] loE;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .startE     (startE),
    .signedE    (signedE),
    .annulE     (annulE),
    .aE         (aE),
    .bE         (bE),
    .stall_divE (stall_divE),
    .div_validE (div_validE),
    .hiE        (hiE),
    .loE        (loE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: quotient truncates toward zero, remainder takes dividend's sign;
  // divide by zero gives all-ones quotient (sign-adjusted) and remainder = a.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  // Issue one division at the next negedge and follow it to DONE.
  task automatic do_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq;
    logic [31:0] er;
    int          stalls;
    int          done_at;
    model(s, a, b, eq, er);
    @(negedge clk);
    startE  = 1'b1;
    signedE = s;
    aE      = a;
    bE      = b;
    #1;
    chk({tag, " valid_at_start"}, {31'd0, div_validE}, 32'd0);
    stalls  = stall_divE ? 1 : 0;
    done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      startE = 1'b0;
      aE     = $urandom;
      bE     = $urandom;
      #1;
      if (div_validE) begin
        done_at = c;
        break;
      end
      if (stall_divE) stalls++;
    end
    chk({tag, " done_cycle"}, 32'(done_at), 32'd33);
    chk({tag, " stall_cycles"}, 32'(stalls), 32'd33);
    if (done_at > 0) begin
      chk({tag, " stall_at_done"}, {31'd0, stall_divE}, 32'd0);
      chk({tag, " lo"}, loE, eq);
      chk({tag, " hi"}, hiE, er);
      last_hi = er;
      last_lo = eq;
    end
  endtask

  initial begin
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1; startE = 1'b0; signedE = 1'b0; annulE = 1'b0; aE = 32'd0; bE = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst hi", hiE, 32'd0);
    chk("rst lo", loE, 32'd0);
    chk("rst valid", {31'd0, div_validE}, 32'd0);
    chk("rst stall", {31'd0, stall_divE}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7);
    do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    do_div("divu 5/0", 1'b0, 32'd5, 32'd0);
    do_div("div 7/0", 1'b1, 32'd7, 32'd0);
    do_div("div -7/0", 1'b1, 32'hFFFF_FFF9, 32'd0);
    do_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div("divu big/0", 1'b0, 32'hFFFF_FFFF, 32'd0);

    // Back to back: second start lands in the IDLE cycle right after DONE.
    do_div("b2b first", 1'b0, 32'd20, 32'd3);
    do_div("b2b second", 1'b0, 32'd9, 32'd4);
    @(negedge clk);
    #1;
    chk("after done valid", {31'd0, div_validE}, 32'd0);
    chk("after done hold lo", loE, last_lo);

    // Annul in BUSY cycle 10.
    @(negedge clk);
    startE = 1'b1; signedE = 1'b0; aE = 32'd1000; bE = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      startE = 1'b0;
    end
    annulE = 1'b1;
    #1;
    chk("annul stall", {31'd0, stall_divE}, 32'd0);
    chk("annul valid", {31'd0, div_validE}, 32'd0);
    chk("annul hi", hiE, last_hi);
    chk("annul lo", loE, last_lo);
    @(negedge clk);
    annulE = 1'b0;
    #1;
    chk("annul idle stall", {31'd0, stall_divE}, 32'd0);
    begin
      int seen_valid = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        #1;
        if (div_validE || stall_divE) seen_valid++;
      end
      chk("annul no activity", 32'(seen_valid), 32'd0);
    end
    chk("annul keep lo", loE, last_lo);

    // Reset mid-BUSY (cycle 5), asserted between clock edges.
    @(negedge clk);
    startE = 1'b1; signedE = 1'b0; aE = 32'd77; bE = 32'd5;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      startE = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("midrst hi", hiE, 32'd0);
    chk("midrst lo", loE, 32'd0);
    chk("midrst stall", {31'd0, stall_divE}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_div("post rst 8/2", 1'b0, 32'd8, 32'd2);

    // Randomized mix, biased toward small divisors and zero.
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 20));
        1:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      do_div($sformatf("rand%0d", i), s, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
